// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences one command at a time through an external one-hot-selected ALU
// Shift commands iterate the ALU's 1-bit shifter once per EXEC cycle.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int SELW  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_cnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam logic [3:0] OP_SHRIGHT = 4'd9;
    localparam logic [3:0] OP_SHLEFT  = 4'd10;
    localparam logic [3:0] OP_LAST    = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state_q;
    logic             cmd_ready_q;
    logic             shift_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [SELW-1:0]  alu_sel_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic cmd_shift_d;
    logic cmd_illegal_d;

    assign cmd_shift_d   = (cmd_op == OP_SHRIGHT) || (cmd_op == OP_SHLEFT);
    assign cmd_illegal_d = (cmd_op > OP_LAST);

    // alu_a_q doubles as the working operand that accumulates each shift step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            shift_q     <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_illegal_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (cmd_shift_d && (cmd_cnt == 4'd0)) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= cmd_a;
                        end else begin
                            state_q   <= S_EXEC;
                            alu_a_q   <= cmd_a;
                            alu_b_q   <= cmd_b;
                            alu_sel_q <= SELW'(1) << cmd_op;
                            shift_q   <= cmd_shift_d;
                            cnt_q     <= cmd_cnt;
                        end
                    end
                end
                S_EXEC: begin
                    if (!shift_q || (cnt_q == 4'd1)) begin
                        state_q     <= S_RESP;
                        alu_sel_q   <= '0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= alu_res;
                    end else begin
                        alu_a_q <= alu_res;
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width.
REQ-002 Parameter SELW, default 12, one-hot ALU select width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_op  input  4  encoded opcode: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 ADD, 8 SUB, 9 SHRIGHT, 10 SHLEFT, 11 CLEAR, 12-15 illegal.
REQ-008 cmd_a, cmd_b  input  WIDTH each  operands.
REQ-009 cmd_cnt  input  4  shift count; used only for SHRIGHT/SHLEFT.
REQ-010 alu_a, alu_b  output  WIDTH each  operands driven to ALU datapath.
REQ-011 alu_sel  output  SELW  one-hot select to ALU result mux; code n drives bit n (AND=bit0 ... CLEAR=bit11).
REQ-012 alu_res  input  WIDTH  combinational ALU result for current alu_a/alu_b/alu_sel.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer takes response.
REQ-015 rsp_data  output  WIDTH  result.
REQ-016 rsp_err  output  1  command had illegal opcode.

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one command in flight; no overlap.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch op, a, b, cnt.
REQ-019 IDLE accept, legal non-shift op -> EXEC; illegal op -> RESP with rsp_err=1, rsp_data=0, no ALU cycle.
REQ-020 IDLE accept, shift op with cnt=0 -> RESP with rsp_data=cmd_a, rsp_err=0, no ALU cycle.
REQ-021 EXEC: alu_a=working A, alu_b=latched B, alu_sel=one-hot of latched op; alu_res captured at end of cycle.
REQ-022 Non-shift op: one EXEC cycle, captured alu_res -> rsp_data, go RESP.
REQ-023 Shift op: ALU shifter moves 1 bit per cycle; each EXEC cycle writes alu_res into working A and decrements remaining count; leave to RESP when count reaches 0 (cnt EXEC cycles total, cnt 1-15).
REQ-024 alu_sel = all zeros in IDLE and RESP; alu_a/alu_b hold last values outside EXEC.
REQ-025 Latency: accept at edge k -> rsp_valid high from cycle after edge k+1 (non-shift), k+cnt (shift), k (illegal / cnt=0, i.e. next cycle).
REQ-026 RESP: rsp_valid=1, cmd_ready=0; rsp_data/rsp_err stable until rsp_valid&rsp_ready; then IDLE same edge.
REQ-027 cmd_ready=0 in EXEC and RESP; cmd_valid ignored there.
REQ-028 Next command accepted no earlier than the cycle after response handshake.
REQ-029 ADD/SUB results taken from alu_res unchanged, WIDTH bits, carry/borrow discarded.
REQ-030 alu_sel always zero-hot or one-hot; never multi-hot.

Reset
REQ-031 reset asserted: immediately state=IDLE, cmd_ready=0 while reset high, rsp_valid=0, rsp_err=0, rsp_data=0, alu_sel=0, alu_a=0, alu_b=0, count=0.
REQ-032 reset during EXEC or RESP aborts command; no response ever issued for it.
REQ-033 First edge after reset deassertion: cmd_ready=1.

Verification
REQ-034 ADD a=0x7FFF b=0x0001 -> alu_sel=0x080 one EXEC cycle; rsp_data=0x8000, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-035 SHLEFT a=0x0001 cnt=4 -> alu_sel=0x400 for exactly 4 cycles, alu_a 0x0001,0x0002,0x0004,0x0008; rsp_data=0x0010.
REQ-036 cmd_op=13 -> no EXEC, alu_sel stays 0, rsp_err=1, rsp_data=0 next cycle.
REQ-037 XOR 0xF0F0^0xFF00 with rsp_ready low 5 cycles -> rsp_data=0x0FF0 held stable, cmd_ready=0 throughout; back-to-back second command accepted only after handshake.
REQ-038 SHRIGHT a=0x8000 cnt=15, reset pulsed on 3rd EXEC cycle -> all outputs zero immediately, no rsp_valid; fresh AND 0x00FF&0x0F0F -> rsp_data=0x000F.
REQ-039 SHRIGHT cnt=0 a=0x1234 -> no EXEC, rsp_data=0x1234 next cycle.
